// File: rtl/commit_msg_tx.sv
// Commit-message broadcaster: on a quorum trigger or heartbeat expiry, snapshots the
// VR state once and unicasts one commit header flit to every other replica in the group.
package commit_msg_tx_pkg;
    typedef struct packed {
        logic [31:0] ip_addr;
        logic [15:0] udp_port;
    } udp_info_t;

    typedef struct packed {
        logic [15:0] curr_view;
        logic [31:0] last_commit;
    } vr_state_t;

    typedef struct packed {
        logic [15:0] view;
        logic [31:0] opnum;
    } commit_msg_hdr_t;

    localparam int COMMIT_MSG_HDR_W = $bits(commit_msg_hdr_t);
endpackage

module commit_msg_tx
    import commit_msg_tx_pkg::*;
#(
    parameter int NOC_DATA_W       = -1,
    parameter int NUM_REPLICAS     = 3,
    parameter int HEARTBEAT_CYCLES = 1024,
    parameter int REPLICA_W        = $clog2(NUM_REPLICAS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  local_is_primary,
    input  logic [REPLICA_W-1:0]  local_replica_idx,
    input  logic                  trig_commit_tx_req_val,
    output logic                  trig_commit_tx_req_rdy,
    output logic                  commit_tx_state_rd_req_val,
    input  logic                  commit_tx_state_rd_req_rdy,
    input  logic                  vr_state_commit_tx_rd_resp_val,
    input  vr_state_t             vr_state_commit_tx_rd_resp_data,
    output logic                  vr_state_commit_tx_rd_resp_rdy,
    output logic [REPLICA_W-1:0]  commit_tx_cfg_rd_addr,
    input  udp_info_t             cfg_commit_tx_rd_data,
    output logic                  commit_tx_pkt_info_val,
    input  logic                  commit_tx_pkt_info_rdy,
    output udp_info_t             commit_tx_pkt_info,
    output logic                  commit_tx_data_val,
    input  logic                  commit_tx_data_rdy,
    output logic [NOC_DATA_W-1:0] commit_tx_data,
    output logic                  commit_tx_data_last
);
    localparam int HB_W = (HEARTBEAT_CYCLES > 1) ? $clog2(HEARTBEAT_CYCLES) : 1;

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        STATE_REQ  = 4'd1,
        STATE_RESP = 4'd2,
        CHECK      = 4'd3,
        CFG_RD     = 4'd4,
        CFG_WAIT   = 4'd5,
        SEND_INFO  = 4'd6,
        SEND_DATA  = 4'd7,
        NEXT       = 4'd8
    } state_e;

    state_e               state_r;
    logic [HB_W-1:0]      hb_cnt_r;
    logic [REPLICA_W-1:0] idx_r;
    vr_state_t            snap_r;
    logic                 hb_expired_s;
    logic                 trig_fire_s;

    // Header occupies the top bits of the flit; everything below it is zero.
    function automatic logic [NOC_DATA_W-1:0] make_flit(input vr_state_t s);
        logic [NOC_DATA_W-1:0] f;
        commit_msg_hdr_t       h;
        h.view  = s.curr_view;
        h.opnum = s.last_commit;
        f       = '0;
        f[NOC_DATA_W-1 -: COMMIT_MSG_HDR_W] = h;
        return f;
    endfunction

    assign hb_expired_s = (hb_cnt_r == HB_W'(HEARTBEAT_CYCLES - 1));
    assign trig_fire_s  = trig_commit_tx_req_val && trig_commit_tx_req_rdy;

    // Broadcast sequencer with all handshake outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r                         <= IDLE;
            hb_cnt_r                        <= '0;
            idx_r                           <= '0;
            snap_r                          <= '0;
            trig_commit_tx_req_rdy          <= 1'b1;
            commit_tx_state_rd_req_val      <= 1'b0;
            vr_state_commit_tx_rd_resp_rdy  <= 1'b0;
            commit_tx_cfg_rd_addr           <= '0;
            commit_tx_pkt_info_val          <= 1'b0;
            commit_tx_pkt_info              <= '0;
            commit_tx_data_val              <= 1'b0;
            commit_tx_data                  <= '0;
            commit_tx_data_last             <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (trig_fire_s || hb_expired_s) begin
                        hb_cnt_r                   <= '0;
                        trig_commit_tx_req_rdy     <= 1'b0;
                        commit_tx_state_rd_req_val <= 1'b1;
                        state_r                    <= STATE_REQ;
                    end else begin
                        hb_cnt_r <= hb_cnt_r + HB_W'(1);
                    end
                end
                STATE_REQ: begin
                    if (commit_tx_state_rd_req_rdy) begin
                        commit_tx_state_rd_req_val     <= 1'b0;
                        vr_state_commit_tx_rd_resp_rdy <= 1'b1;
                        state_r                        <= STATE_RESP;
                    end
                end
                STATE_RESP: begin
                    if (vr_state_commit_tx_rd_resp_val) begin
                        snap_r                         <= vr_state_commit_tx_rd_resp_data;
                        vr_state_commit_tx_rd_resp_rdy <= 1'b0;
                        state_r                        <= CHECK;
                    end
                end
                CHECK: begin
                    if (local_is_primary) begin
                        idx_r                 <= '0;
                        commit_tx_cfg_rd_addr <= '0;
                        state_r               <= CFG_RD;
                    end else begin
                        trig_commit_tx_req_rdy <= 1'b1;
                        state_r                <= IDLE;
                    end
                end
                // The table address is already on the port while in CFG_RD, so the
                // read data is valid during CFG_WAIT and captured at its end.
                CFG_RD: begin
                    if (idx_r == local_replica_idx) begin
                        state_r <= NEXT;
                    end else begin
                        state_r <= CFG_WAIT;
                    end
                end
                CFG_WAIT: begin
                    commit_tx_pkt_info     <= cfg_commit_tx_rd_data;
                    commit_tx_pkt_info_val <= 1'b1;
                    state_r                <= SEND_INFO;
                end
                SEND_INFO: begin
                    if (commit_tx_pkt_info_rdy) begin
                        commit_tx_pkt_info_val <= 1'b0;
                        commit_tx_data         <= make_flit(snap_r);
                        commit_tx_data_last    <= 1'b1;
                        commit_tx_data_val     <= 1'b1;
                        state_r                <= SEND_DATA;
                    end
                end
                SEND_DATA: begin
                    if (commit_tx_data_rdy) begin
                        commit_tx_data_val  <= 1'b0;
                        commit_tx_data_last <= 1'b0;
                        state_r             <= NEXT;
                    end
                end
                NEXT: begin
                    if (idx_r == REPLICA_W'(NUM_REPLICAS - 1)) begin
                        trig_commit_tx_req_rdy <= 1'b1;
                        state_r                <= IDLE;
                    end else begin
                        idx_r                 <= idx_r + REPLICA_W'(1);
                        commit_tx_cfg_rd_addr <= idx_r + REPLICA_W'(1);
                        state_r               <= CFG_RD;
                    end
                end
                default: begin
                    trig_commit_tx_req_rdy         <= 1'b1;
                    commit_tx_state_rd_req_val     <= 1'b0;
                    vr_state_commit_tx_rd_resp_rdy <= 1'b0;
                    commit_tx_pkt_info_val         <= 1'b0;
                    commit_tx_data_val             <= 1'b0;
                    commit_tx_data_last            <= 1'b0;
                    state_r                        <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_commit_msg_tx.sv
// Randomized bench for commit_msg_tx: a transaction-level model predicts the
// (destination, flit) sequence of every broadcast and the heartbeat start times.
module tb_commit_msg_tx;
    import commit_msg_tx_pkg::*;

    localparam int NOC_W = 64;
    localparam int NREP  = 3;
    localparam int HB    = 8;
    localparam int RW    = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             local_is_primary = 1'b1;
    logic [RW-1:0]    local_replica_idx = '0;
    logic             trig_val = 1'b0;
    logic             trig_rdy;
    logic             rd_req_val;
    logic             rd_req_rdy = 1'b0;
    logic             resp_val = 1'b0;
    vr_state_t        resp_data = '0;
    logic             resp_rdy;
    logic [RW-1:0]    cfg_addr;
    udp_info_t        cfg_data = '0;
    logic             pkt_val;
    logic             pkt_rdy = 1'b0;
    udp_info_t        pkt_info;
    logic             data_val;
    logic             data_rdy = 1'b0;
    logic [NOC_W-1:0] data;
    logic             data_last;

    always #5 clk = ~clk;

    commit_msg_tx #(.NOC_DATA_W(NOC_W), .NUM_REPLICAS(NREP), .HEARTBEAT_CYCLES(HB)) dut (
        .clk(clk), .rst(rst),
        .local_is_primary(local_is_primary), .local_replica_idx(local_replica_idx),
        .trig_commit_tx_req_val(trig_val), .trig_commit_tx_req_rdy(trig_rdy),
        .commit_tx_state_rd_req_val(rd_req_val), .commit_tx_state_rd_req_rdy(rd_req_rdy),
        .vr_state_commit_tx_rd_resp_val(resp_val), .vr_state_commit_tx_rd_resp_data(resp_data),
        .vr_state_commit_tx_rd_resp_rdy(resp_rdy),
        .commit_tx_cfg_rd_addr(cfg_addr), .cfg_commit_tx_rd_data(cfg_data),
        .commit_tx_pkt_info_val(pkt_val), .commit_tx_pkt_info_rdy(pkt_rdy),
        .commit_tx_pkt_info(pkt_info),
        .commit_tx_data_val(data_val), .commit_tx_data_rdy(data_rdy),
        .commit_tx_data(data), .commit_tx_data_last(data_last)
    );

    int n_chk = 0, n_fail = 0;
    udp_info_t table_m [NREP];
    bit  rst_req = 1'b1, trig_req = 1'b0, trig_rand = 1'b0, st_fixed = 1'b0;
    int  data_rdy_mode = 0;
    bit  primary_next = 1'b1;
    logic [RW-1:0] local_next = '0;
    bit  rst_sampled = 1'b1;
    int  idle_cnt = 0;
    bit  exp_start_valid = 1'b0, exp_start = 1'b0;
    bit  req_pending = 1'b0, info_taken = 1'b0;
    bit  hold_pkt = 1'b0, hold_data = 1'b0;
    udp_info_t held_pkt;
    logic [NOC_W-1:0] held_data;
    logic [RW-1:0] prev_addr = '0;
    udp_info_t exp_info_q[$];
    logic [NOC_W-1:0] exp_data_q[$];
    udp_info_t log_info[$];
    logic [NOC_W-1:0] log_data[$];
    int n_state_reads = 0, n_flits = 0, n_infos = 0, n_trig_acc = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One bench clock: check outputs against predictions, drive inputs, then
    // evaluate which handshakes complete at the coming rising edge.
    task automatic cycle();
        bit tfire;
        @(negedge clk);
        if (rst_sampled) begin
            check_eq("rst_trig_rdy", trig_rdy, 1);
            check_eq("rst_rd_req_val", rd_req_val, 0);
            check_eq("rst_resp_rdy", resp_rdy, 0);
            check_eq("rst_pkt_val", pkt_val, 0);
            check_eq("rst_data_val", data_val, 0);
            check_eq("rst_data_last", data_last, 0);
            check_eq("rst_data", data, 0);
            check_eq("rst_pkt_info", pkt_info, 0);
            check_eq("rst_cfg_addr", cfg_addr, 0);
            idle_cnt = 0; req_pending = 0; info_taken = 0;
            hold_pkt = 0; hold_data = 0; exp_start_valid = 0;
            exp_info_q.delete(); exp_data_q.delete();
        end else begin
            if (exp_start_valid) begin
                check_eq("start_rd_req_val", rd_req_val, exp_start);
                check_eq("start_trig_rdy", trig_rdy, !exp_start);
            end
            if (hold_pkt) begin
                check_eq("pkt_hold_val", pkt_val, 1);
                check_eq("pkt_hold_info", pkt_info, held_pkt);
            end
            if (hold_data) begin
                check_eq("data_hold_val", data_val, 1);
                check_eq("data_hold_flit", data, held_data);
            end
            if (req_pending || exp_data_q.size() != 0) check_eq("busy_trig_rdy", trig_rdy, 0);
        end

        rst        = rst_req;
        trig_val   = trig_rand ? ($urandom_range(3) == 0) : trig_req;
        rd_req_rdy = ($urandom_range(3) != 0);
        resp_val   = req_pending && ($urandom_range(2) != 0);
        if (st_fixed) begin
            resp_data.curr_view   = 16'd5;
            resp_data.last_commit = 32'd17;
        end else begin
            resp_data.curr_view   = 16'($urandom);
            resp_data.last_commit = $urandom;
        end
        cfg_data  = (int'(prev_addr) < NREP) ? table_m[prev_addr] : '0;
        prev_addr = cfg_addr;
        pkt_rdy   = ($urandom_range(3) != 0);
        data_rdy  = (data_rdy_mode == 1) ? 1'b0 :
                    (data_rdy_mode == 2) ? 1'b1 : ($urandom_range(3) != 0);
        if (trig_rdy) begin
            local_is_primary  = primary_next;
            local_replica_idx = local_next;
        end

        if (!rst) begin
            if (trig_rdy) begin
                tfire = trig_val;
                if (tfire) n_trig_acc++;
                exp_start = tfire || (idle_cnt == HB - 1);
                idle_cnt  = exp_start ? 0 : idle_cnt + 1;
                exp_start_valid = 1;
            end else begin
                exp_start_valid = 0;
            end
            if (resp_rdy && resp_val) begin
                req_pending = 0;
                if (local_is_primary) begin
                    for (int r = 0; r < NREP; r++) begin
                        if (r != int'(local_replica_idx)) begin
                            exp_info_q.push_back(table_m[r]);
                            exp_data_q.push_back({resp_data.curr_view, resp_data.last_commit, 16'h0000});
                        end
                    end
                end
            end
            if (rd_req_val && rd_req_rdy) begin
                check_eq("rd_req_unexpected", req_pending, 0);
                req_pending = 1;
                n_state_reads++;
            end
            if (pkt_val && pkt_rdy) begin
                check_eq("pkt_expected", (exp_info_q.size() != 0) && !info_taken, 1);
                if (exp_info_q.size() != 0) check_eq("pkt_info", pkt_info, exp_info_q[0]);
                info_taken = 1;
                n_infos++;
                log_info.push_back(pkt_info);
            end
            if (data_val && data_rdy) begin
                check_eq("data_expected", (exp_data_q.size() != 0) && info_taken, 1);
                if (exp_data_q.size() != 0) begin
                    check_eq("data_flit", data, exp_data_q[0]);
                    void'(exp_data_q.pop_front());
                    void'(exp_info_q.pop_front());
                end
                check_eq("data_last", data_last, 1);
                info_taken = 0;
                n_flits++;
                log_data.push_back(data);
            end
            hold_pkt  = pkt_val && !pkt_rdy;
            held_pkt  = pkt_info;
            hold_data = data_val && !data_rdy;
            held_data = data;
        end else begin
            exp_start_valid = 0;
            hold_pkt = 0;
            hold_data = 0;
        end
        rst_sampled = rst;
    endtask

    task automatic wait_idle();
        bit found = 0;
        for (int k = 0; k < 300 && !found; k++) begin
            cycle();
            if (trig_rdy && !req_pending && exp_data_q.size() == 0) found = 1;
        end
        check_eq("idle_reached", found, 1);
    endtask

    task automatic measure_hb();
        int n = 1;
        bit seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            cycle();
            if (rd_req_val) seen = 1;
            else n++;
        end
        check_eq("hb_seen", seen, 1);
        check_eq("hb_idle_cycles", n, HB);
    endtask

    task automatic wait_data_val();
        bit seen = 0;
        for (int k = 0; k < 100 && !seen; k++) begin
            cycle();
            if (data_val) seen = 1;
        end
        check_eq("data_val_seen", seen, 1);
    endtask

    initial begin
        int b_reads, b_flits, b_infos, b_trig;
        for (int r = 0; r < NREP; r++) table_m[r] = {$urandom, 16'($urandom)};
        repeat (2) cycle();

        // Primary, idx 0, view 5, commit 17: two flits to replicas 1 and 2.
        rst_req = 0; trig_req = 1; st_fixed = 1;
        cycle();
        trig_req = 0;
        wait_idle();
        check_eq("bc1_flits", n_flits, 2);
        check_eq("bc1_reads", n_state_reads, 1);
        check_eq("bc1_dst0", log_info[0], table_m[1]);
        check_eq("bc1_dst1", log_info[1], table_m[2]);
        check_eq("bc1_flit0", log_data[0], 64'h0005_0000_0011_0000);
        check_eq("bc1_flit1", log_data[1], 64'h0005_0000_0011_0000);
        st_fixed = 0;

        // Non-primary: state read happens, nothing is sent.
        primary_next = 0;
        b_reads = n_state_reads; b_flits = n_flits; b_infos = n_infos;
        trig_req = 1;
        cycle();
        trig_req = 0;
        wait_idle();
        check_eq("np_reads", n_state_reads - b_reads, 1);
        check_eq("np_flits", n_flits - b_flits, 0);
        check_eq("np_infos", n_infos - b_infos, 0);
        check_eq("np_trig_rdy", trig_rdy, 1);

        // Heartbeat period, then again after a heartbeat broadcast completes.
        primary_next = 1; local_next = 2'd1;
        measure_hb();
        wait_idle();
        measure_hb();
        wait_idle();

        // Payload back-pressure with a trigger held high throughout.
        data_rdy_mode = 1; trig_req = 1;
        wait_data_val();
        for (int k = 0; k < 20; k++) begin
            cycle();
            check_eq("bp_data_val", data_val, 1);
            check_eq("bp_trig_rdy", trig_rdy, 0);
        end
        b_flits = n_flits;
        data_rdy_mode = 2;
        cycle();
        check_eq("bp_release_one", n_flits - b_flits, 1);
        trig_req = 0; data_rdy_mode = 0;
        wait_idle();

        // Trigger coincident with the 8th idle cycle: single broadcast.
        b_reads = n_state_reads; b_trig = n_trig_acc; b_flits = n_flits;
        repeat (HB - 2) cycle();
        trig_req = 1;
        cycle();
        trig_req = 0;
        wait_idle();
        check_eq("coin_reads", n_state_reads - b_reads, 1);
        check_eq("coin_trig_acc", n_trig_acc - b_trig, 1);
        check_eq("coin_flits", n_flits - b_flits, 2);

        // Reset while a flit is waiting in SEND_DATA.
        data_rdy_mode = 1; trig_req = 1;
        cycle();
        trig_req = 0;
        wait_data_val();
        rst_req = 1;
        cycle();
        rst_req = 0; data_rdy_mode = 2;
        b_flits = n_flits;
        cycle();
        check_eq("rstsd_data_val", data_val, 0);
        repeat (5) cycle();
        check_eq("rstsd_no_flit", n_flits - b_flits, 0);
        data_rdy_mode = 0;

        // Randomized traffic: triggers, ready stalls, role and index changes.
        trig_rand = 1;
        for (int k = 0; k < 1500; k++) begin
            primary_next = ($urandom_range(7) != 0);
            local_next   = RW'($urandom_range(NREP - 1));
            cycle();
        end
        trig_rand = 0;
        wait_idle();
        check_eq("rand_queue_empty", exp_data_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
